// File: rtl/rs_pkg.sv
// Shared IEEE-754 single-precision constants, field view and flag positions for the sqrt arbiter.
// Latency: none (types, constants and a pure function only).
// Backpressure: not applicable.
package rs_pkg;

  localparam logic [7:0]  FP_EXP_MAX = 8'hFF;
  localparam logic [31:0] FP_POS_INF = 32'h7F800000;
  localparam logic [31:0] FP_QNAN    = 32'h7FC00000;

  // Bit positions inside rsp_flags = {pos_inf, neg_invalid, nan_in}
  localparam int FLAG_NAN_IN  = 0;
  localparam int FLAG_NEG_INV = 1;
  localparam int FLAG_POS_INF = 2;

  typedef struct packed {
    logic        sign;
    logic [7:0]  exp;
    logic [22:0] mant;
  } fp32_t;

`ifdef RS_ARB_FLAGS_EN
  // Classify an operand: NaN, negative non-zero (invalid for sqrt), or +inf; -0 raises nothing
  function automatic logic [2:0] fp_classify(input fp32_t x);
    logic [2:0] f;
    f = '0;
    f[FLAG_NAN_IN]  = (x.exp == FP_EXP_MAX) && (x.mant != '0);
    f[FLAG_NEG_INV] = x.sign && !f[FLAG_NAN_IN] && ({x.exp, x.mant} != '0);
    f[FLAG_POS_INF] = (x == FP_POS_INF);
    return f;
  endfunction
`endif

endpackage

// File: rtl/rs.sv
// Combinational single-precision square root, round-to-nearest-even; subnormal inputs flush to zero.
// Latency: 0 cycles (pure combinational).
// Backpressure: none; output follows the input every cycle.
module rs
  import rs_pkg::*;
(
  input  logic [31:0] in,
  output logic [31:0] S
);

  fp32_t       x;
  logic [49:0] rad;
  logic [24:0] q;
  logic [27:0] r;
  logic [27:0] t;
  logic [8:0]  res_e;
  logic        rnd_up;
  logic [31:0] norm;

  // Digit-by-digit root of the significand scaled to 2^48, then rounding and special-case selection
  always_comb begin
    x     = in;
    // An odd unbiased exponent (even biased) folds one factor of 2 into the radicand
    rad   = x.exp[0] ? {2'b01, x.mant, 25'b0} : {1'b1, x.mant, 26'b0};
    q     = '0;
    r     = '0;
    t     = '0;
    for (int i = 24; i >= 0; i--) begin
      r = {r[25:0], rad[2*i+1 -: 2]};
      t = {1'b0, q, 2'b01};
      if (r >= t) begin
        r = r - t;
        q = {q[23:0], 1'b1};
      end else begin
        q = {q[23:0], 1'b0};
      end
    end
    // (e + 127) >> 1 is floor((e - 127) / 2) + 127 for every normal e; bit 8 is always 0
    res_e  = ({1'b0, x.exp} + 9'd127) >> 1;
    rnd_up = q[0] && (q[1] || (r != '0));
    // A round-up carry out of the fraction lands in the exponent field
    norm   = {res_e, q[23:1]} + {31'b0, rnd_up};

    if ((x.exp == FP_EXP_MAX) && (x.mant != '0)) begin
      S = FP_QNAN;
    end else if (x.sign && ({x.exp, x.mant} != '0)) begin
      S = FP_QNAN;
    end else if (x.exp == FP_EXP_MAX) begin
      S = FP_POS_INF;
    end else if (x.exp == '0) begin
      S = {x.sign, 31'b0};
    end else begin
      S = norm;
    end
  end

endmodule

// File: rtl/rs_arbiter.sv
// Round-robin share of one sqrt unit between NREQ requesters; optional rsp_flags via RS_ARB_FLAGS_EN.
// Latency: 2 cycles from accept to rsp_valid (operand register, result register), 1 result/cycle.
// Backpressure: rsp_ready low holds S2; once S1 is also full req_ready drops to 0 in the same cycle.
module rs_arbiter
  import rs_pkg::*;
#(
  parameter int NREQ = 4,
  parameter int IDW  = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NREQ-1:0]      req_valid,
  input  logic [32*NREQ-1:0]   req_data,
  output logic [NREQ-1:0]      req_ready,
  output logic                 rsp_valid,
  output logic [31:0]          rsp_data,
  output logic [IDW-1:0]       rsp_id,
  input  logic                 rsp_ready,
`ifdef RS_ARB_FLAGS_EN
  output logic [2:0]           rsp_flags,
`endif
  output logic                 busy
);

  logic           adv1;
  logic           adv2;
  logic [IDW-1:0] ptr;
  logic           gnt_any;
  logic [IDW-1:0] gnt_idx;
  logic [31:0]    gnt_data;

  logic           s1_valid;
  logic [31:0]    s1_data;
  logic [IDW-1:0] s1_id;
  logic           s2_valid;
  logic [31:0]    s2_data;
  logic [IDW-1:0] s2_id;
  logic [31:0]    rs_out;
`ifdef RS_ARB_FLAGS_EN
  logic [2:0]     s2_flags;
`endif

  assign adv2 = !s2_valid || rsp_ready;
  assign adv1 = !s1_valid || adv2;

  // Pick the first valid requester at or above ptr, wrapping; suppressed in reset or when S1 cannot move
  always_comb begin
    gnt_any = 1'b0;
    gnt_idx = '0;
    for (int k = 0; k < NREQ; k++) begin
      if (!gnt_any && req_valid[IDW'((int'(ptr) + k) % NREQ)]) begin
        gnt_any = 1'b1;
        gnt_idx = IDW'((int'(ptr) + k) % NREQ);
      end
    end
    if (rst || !adv1) begin
      gnt_any = 1'b0;
    end
  end

  assign req_ready = gnt_any ? (NREQ'(1) << gnt_idx) : '0;

  // Operand lane of the granted requester
  always_comb begin
    gnt_data = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (gnt_idx == IDW'(i)) begin
        gnt_data = req_data[32*i +: 32];
      end
    end
  end

  // Pointer moves one past the winner so the winner becomes lowest priority next round
  always_ff @(posedge clk) begin
    if (rst) begin
      ptr <= '0;
    end else if (gnt_any) begin
      ptr <= (gnt_idx == IDW'(NREQ - 1)) ? '0 : gnt_idx + IDW'(1);
    end
  end

  // S1 operand register; it drives the shared sqrt unit directly
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s1_data  <= '0;
      s1_id    <= '0;
    end else if (adv1) begin
      s1_valid <= gnt_any;
      if (gnt_any) begin
        s1_data <= gnt_data;
        s1_id   <= gnt_idx;
      end
    end
  end

  rs u_rs (
    .in (s1_data),
    .S  (rs_out)
  );

  // S2 result register; holds while the consumer stalls so a pending result never changes
  always_ff @(posedge clk) begin
    if (rst) begin
      s2_valid <= 1'b0;
      s2_data  <= '0;
      s2_id    <= '0;
`ifdef RS_ARB_FLAGS_EN
      s2_flags <= '0;
`endif
    end else if (adv2) begin
      s2_valid <= s1_valid;
      s2_data  <= rs_out;
      s2_id    <= s1_id;
`ifdef RS_ARB_FLAGS_EN
      s2_flags <= fp_classify(s1_data);
`endif
    end
  end

  assign rsp_valid = s2_valid;
  assign rsp_data  = s2_data;
  assign rsp_id    = s2_id;
`ifdef RS_ARB_FLAGS_EN
  assign rsp_flags = s2_flags;
`endif
  assign busy      = s1_valid || s2_valid;

endmodule

// File: doc/rs_arbiter.md
# rs_arbiter

Shares one combinational single-precision square-root unit (`rs`) between NREQ requesters. Round-robin arbitration, a registered operand stage, the `rs` datapath and a registered result stage with valid/ready backpressure. Sits between the FPAU issue logic and the sqrt datapath. It sustains one square root per cycle with a fixed 2-cycle latency.

## Interface
- NREQ, 4, number of requesters (2..8)
- IDW, 2, requester-id width; must equal clog2(NREQ)
- clk  in  1  rising-edge clock
- rst  in  1  reset; synchronous, active-high
- req_valid  in  NREQ  per-requester operand valid
- req_data  in  32*NREQ  flattened IEEE-754 operands; requester i occupies bits [32*i+31:32*i]
- req_ready  out  NREQ  one-hot grant; operand i is accepted on a cycle where req_valid[i] and req_ready[i] are both high
- rsp_valid  out  1  result valid
- rsp_data  out  32  square root from `rs`
- rsp_id  out  IDW  index of the requester that owns rsp_data
- rsp_ready  in  1  consumer accepts the result on the cycle rsp_valid and rsp_ready are both high
- rsp_flags  out  3  {pos_inf, neg_invalid, nan_in}; present only with RS_ARB_FLAGS_EN
- busy  out  1  s1_valid | s2_valid

## Operation
- Pipeline:
  - S1 holds {operand, id, valid} and drives `rs` directly.
  - S2 registers {rs result, id, flags, valid}.
- Advance rules:
  - adv2 = !s2_valid | rsp_ready
  - adv1 = !s1_valid | adv2
- Grant:
  - req_ready is all-zero when rst or !adv1.
  - Otherwise it asserts exactly one bit: the first set req_valid bit searched from ptr upward, wrapping modulo NREQ.
  - req_ready is combinational on req_valid. Requesters must not make req_valid depend on req_ready.
- Pointer:
  - ptr resets to 0.
  - On an accept by requester g, ptr <= (g+1) mod NREQ.
  - With no accept, ptr holds.
- S1 update when adv1: s1_valid <= any grant; operand and id load only on an accept.
- S2 update when adv2: s2_valid <= s1_valid; data, id and flags load from S1/`rs`.
- When stalled (!adv2), S2 and rsp_* hold stable. A valid result is never dropped or changed until accepted.
- Data: rsp_data is exactly the `rs` output for the operand; there is no rounding or substitution in this block.
- No requester is starved: with all requesters valid and rsp_ready=1, grants rotate 0,1,…,NREQ-1,0.
- Reset mid-operation: in-flight S1/S2 contents are discarded with no response. The requester must re-issue.

## Timing
- Reset values: rsp_valid=0, rsp_data=32'h0, rsp_id=0, rsp_flags=0, busy=0, req_ready=0 while rst is high, ptr=0.
- Latency: operand accepted at edge N → rsp_valid high after edge N+2. That is 2 cycles, fixed, when not stalled.
- Throughput: 1 accept per cycle while rsp_ready=1.
- Full pipeline with rsp_ready=0: req_ready goes 0 in the same cycle. The two held operands resume in order once rsp_ready rises.
- Simultaneous S2 accept and new S1 load in the same cycle is legal. There is no bubble.

## Configuration
- RS_ARB_FLAGS_EN defined:
  - rsp_flags exists and is classified from the S1 operand, registered alongside the data.
  - nan_in: exp=8'hFF and mant≠0.
  - neg_invalid: sign=1, not NaN, not ±0.
  - pos_inf: operand = 32'h7F800000.
  - -0 sets no flag.
- RS_ARB_FLAGS_EN undefined: no rsp_flags port and no classification logic. The datapath is otherwise identical.

## Structure
- Shared package/include `rs_pkg`: FP_EXP_MAX (8'hFF), FP_POS_INF (32'h7F800000), FP_QNAN (32'h7FC00000), and the flag bit positions.
- One sub-module: the existing `rs` (output S, input in), instantiated once on the S1 operand.
- The round-robin picker stays inline; no separate module.

## Test plan
- Single request: req 0 = 32'h40800000 (4.0) → rsp_data=32'h40000000, rsp_id=0, 2 cycles after accept.
- All four valid continuously with rsp_ready=1, operands 32'h41800000/41100000/40800000/3F800000 → grants 0,1,2,3,0. Results 32'h40800000/40400000/40000000/3F800000 back-to-back, one per cycle.
- Backpressure: rsp_ready=0 for 5 cycles with a 3-deep burst → req_ready=0 after 2 accepts. rsp_data/rsp_id stable throughout. All 3 results delivered in order after release.
- Flags (RS_ARB_FLAGS_EN): inputs 32'hC0875C29 → flags 3'b010; 32'h7FFFFFFF → 3'b001; 32'h7F800000 → 3'b100; 32'h80000000 → 3'b000.
- Reset with both stages valid → next cycle rsp_valid=0, busy=0, ptr=0. The first post-reset grant goes to the lowest valid requester.
- Fairness: requester 2 held valid, requester 0 re-asserting every cycle → requester 2 is granted within 2 accepts.
